jt_err_mult: RTL
================

JT_ERR_MULT -- requirements
Module: jt_err_mult

Interface
REQ-001 SHALL have parameter N, default 6, meaning the number of joints (matrix dimension).
REQ-002 SHALL have parameter W, default 27, meaning the signed fixed-point data width.
REQ-003 SHALL have parameter FRAC, default 22, meaning fractional bits (1.0 = 0x400000).
REQ-004 SHALL have parameter ACC_W, default 36, meaning the accumulator width.
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  global enable; when low, all state and outputs hold.
REQ-008 start  input  1  request to begin one computation.
REQ-009 jacobian  input  [N][N]xW  full Jacobian from full_mat, row-major, signed.
REQ-010 error  input  [N]xW  task-space error vector, signed.
REQ-011 alpha  input  W  step gain, signed.
REQ-012 busy  output  1  high from the accepted start until done inclusive.
REQ-013 done  output  1  one-cycle pulse when dtheta is valid.
REQ-014 dtheta  output  [N]xW  joint update = alpha * J^T * error, signed.

Function
REQ-015 SHALL implement an FSM with states IDLE, MAC, SCALE, DONE; all transitions SHALL occur only on cycles where en=1.
REQ-016 In IDLE with en=1 and start=1, the block SHALL capture jacobian, error and alpha into internal registers, clear accumulators, set k=0, and go to MAC.
REQ-017 In MAC, each enabled cycle SHALL add J[k][i]*e[k] (full 2W-bit product, arithmetic-shifted right by FRAC, sign-extended to ACC_W) to acc[i] for all i in parallel, then increment k; after k=N-1 the FSM SHALL go to SCALE.
REQ-018 In SCALE, dtheta[i] SHALL be registered as (sat_W(acc[i]) * alpha) >> FRAC, saturated to W bits; the FSM then goes to DONE.
REQ-019 Saturation SHALL clamp to 0x3FFFFFF (max positive) and 0x4000000 (min negative); no wrap-around is permitted.
REQ-020 In DONE, done SHALL be 1 for exactly one enabled cycle; the FSM then returns to IDLE.
REQ-021 Latency with en held high: start sampled at cycle 0, MAC at cycles 1..N, SCALE at cycle N+1, done=1 at cycle N+2 (cycle 8 for N=6).
REQ-022 When en=0 mid-operation, the FSM, k, accumulators and done SHALL hold; a held done remains high until the next enabled cycle.
REQ-023 start while busy=1 SHALL be ignored; start in DONE SHALL NOT be accepted until IDLE.
REQ-024 dtheta SHALL hold its last value from SCALE until the next SCALE; inputs SHALL be ignored outside the capture cycle.

Reset
REQ-025 rst=1 SHALL take priority over en, start and every state.
REQ-026 On reset, the FSM SHALL return to IDLE and k, acc, dtheta, busy and done SHALL be 0.
REQ-027 Reset during MAC or SCALE SHALL abort the computation without asserting done.

Structure
REQ-028 A shared package jt_pkg SHALL hold N, W, FRAC, ACC_W, the FSM state enum, and the saturation function.
REQ-029 One sub-module, jt_mac_lane (one accumulator plus multiplier for one column i), SHALL be instantiated N times via generate.
REQ-030 The top level SHALL contain only the FSM, the k counter, the input capture registers and the scale stage.

Verification
REQ-031 J=identity (diagonal 0x400000), error[i]=0x400000*(i+1), alpha=0x400000, start at cycle 0 -> done=1 at cycle 8, dtheta[i]=0x400000*(i+1).
REQ-032 All J entries = 0x400000, error all 0x400000, alpha=0x200000 (0.5) -> every dtheta = 0xC00000 (3.0).
REQ-033 All J and error = 0x3FFFFFF, alpha=0x400000 -> every dtheta = 0x3FFFFFF (positive saturation); with error negated -> 0x4000000.
REQ-034 en low for 3 cycles during MAC -> done at cycle 11, results identical to REQ-031.
REQ-035 Second start pulse at cycle 3 -> ignored; exactly one done, at cycle 8.
REQ-036 rst at cycle 4 -> no done; busy=0 and dtheta=0 from cycle 5; a new start afterwards completes normally.

Source files
------------

// File: rtl/jt_pkg.sv
// rtl/jt_pkg.sv - shared sizes, FSM state type and saturation helper for jt_err_mult
package jt_pkg;

   localparam int N     = 6;
   localparam int W     = 27;
   localparam int FRAC  = 22;
   localparam int ACC_W = 36;

   typedef enum logic [1:0] {IDLE, MAC, SCALE, DONE} state_t;

   // Clamp a sign-extended value into the signed range of a w-bit word.
   function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi)
         return hi;
      else if (x < lo)
         return lo;
      else
         return x;
   endfunction

endpackage

// File: rtl/jt_mac_lane.sv
// rtl/jt_mac_lane.sv - one column accumulator: acc += (J[k][i] * e[k]) >>> FRAC
module jt_mac_lane #(
   parameter int W     = jt_pkg::W,
   parameter int FRAC  = jt_pkg::FRAC,
   parameter int ACC_W = jt_pkg::ACC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    clr,
   input  logic                    mac,
   input  logic signed [W-1:0]     j_in,
   input  logic signed [W-1:0]     e_in,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [2*W-1:0]   prod;
   logic signed [2*W-1:0]   prod_sh;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] acc_q;

   always_comb begin
      prod    = (2*W)'(j_in) * (2*W)'(e_in);
      prod_sh = prod >>> FRAC;
      acc_d   = acc_q;
      if (clr)
         acc_d = '0;
      else if (mac)
         acc_d = acc_q + ACC_W'(prod_sh);
   end

   always_ff @(posedge clk) begin
      if (rst)
         acc_q <= '0;
      else if (en)
         acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/jt_err_mult.sv
// rtl/jt_err_mult.sv - dtheta = alpha * J^T * error, one Jacobian row per MAC cycle
module jt_err_mult import jt_pkg::*; #(
   parameter int N     = jt_pkg::N,
   parameter int W     = jt_pkg::W,
   parameter int FRAC  = jt_pkg::FRAC,
   parameter int ACC_W = jt_pkg::ACC_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          start,
   input  logic [N-1:0][N-1:0][W-1:0]    jacobian,
   input  logic [N-1:0][W-1:0]           error,
   input  logic [W-1:0]                  alpha,
   output logic                          busy,
   output logic                          done,
   output logic [N-1:0][W-1:0]           dtheta
);

   localparam int KW = (N > 1) ? $clog2(N) : 1;

   state_t                        state_d, state_q;
   logic [KW-1:0]                 k_d, k_q;
   logic [N-1:0][N-1:0][W-1:0]    j_d, j_q;
   logic [N-1:0][W-1:0]           e_d, e_q;
   logic signed [W-1:0]           alpha_d, alpha_q;
   logic [N-1:0][W-1:0]           dtheta_d, dtheta_q;
   logic                          busy_d, busy_q;
   logic                          done_d, done_q;
   logic                          lane_clr, lane_mac;

   logic signed [ACC_W-1:0]       acc [N];
   logic [N-1:0][W-1:0]           scale_d;
   logic signed [63:0]            acc64;
   logic signed [W-1:0]           acc_sat;
   logic signed [2*W-1:0]         scaled;

   // Column i of J^T * e is row-sweep over k of J[k][i] * e[k].
   for (genvar i = 0; i < N; i++) begin : g_lane
      jt_mac_lane #(.W(W), .FRAC(FRAC), .ACC_W(ACC_W)) u_lane (
         .clk  (clk),
         .rst  (rst),
         .en   (en),
         .clr  (lane_clr),
         .mac  (lane_mac),
         .j_in (j_q[k_q][i]),
         .e_in (e_q[k_q]),
         .acc  (acc[i])
      );
   end

   // Accumulator is clamped to W bits before the gain so the product stays within 2W.
   always_comb begin
      scale_d = '0;
      acc64   = '0;
      acc_sat = '0;
      scaled  = '0;
      for (int i = 0; i < N; i++) begin
         acc64      = 64'(acc[i]);
         acc_sat    = W'(sat(acc64, W));
         scaled     = (2*W)'(acc_sat) * (2*W)'(alpha_q);
         scale_d[i] = W'(sat(64'(scaled >>> FRAC), W));
      end
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      j_d      = j_q;
      e_d      = e_q;
      alpha_d  = alpha_q;
      dtheta_d = dtheta_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      lane_clr = 1'b0;
      lane_mac = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               j_d      = jacobian;
               e_d      = error;
               alpha_d  = alpha;
               k_d      = '0;
               lane_clr = 1'b1;
               busy_d   = 1'b1;
               state_d  = MAC;
            end
         end
         MAC: begin
            lane_mac = 1'b1;
            if (k_q == KW'(N - 1))
               state_d = SCALE;
            else
               k_d = k_q + 1'b1;
         end
         SCALE: begin
            dtheta_d = scale_d;
            done_d   = 1'b1;
            state_d  = DONE;
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         k_q      <= '0;
         j_q      <= '0;
         e_q      <= '0;
         alpha_q  <= '0;
         dtheta_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (en) begin
         state_q  <= state_d;
         k_q      <= k_d;
         j_q      <= j_d;
         e_q      <= e_d;
         alpha_q  <= alpha_d;
         dtheta_q <= dtheta_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign dtheta = dtheta_q;

endmodule
